// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry helpers for the dcache store responder.
//   type_dcache_resp_state_e : responder FSM states
//   type_dcache_line_t       : one array line {valid, tag, data}, sized for the widest build
//   calc_idx_w / calc_tag_w  : index and tag widths from the address/line parameters
package dcache_pkg;

  // Line fields are sized for the largest supported geometry; narrower builds
  // zero-extend into them.
  localparam int unsigned LINE_TAG_MAX_W  = 64;
  localparam int unsigned LINE_DATA_MAX_W = 64;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StMemWr,
    StAck
  } type_dcache_resp_state_e;

  typedef struct packed {
    logic                       valid;
    logic [LINE_TAG_MAX_W-1:0]  tag;
    logic [LINE_DATA_MAX_W-1:0] data;
  } type_dcache_line_t;

  function automatic int unsigned calc_idx_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  // Two bits of byte offset sit below the index.
  function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                             input int unsigned num_lines);
    return addr_w - 2 - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dcache_wr_array.sv
// dcache_wr_array: direct-mapped one-word-per-line tag/valid/data storage.
// Ports:
//   clk, rst_n    clock, async active-low reset (clears valid bits only)
//   i_idx         line index for both the read and the write
//   i_wr_en       byte-masked write of data and tag at i_idx
//   i_wr_tag      tag written with the data
//   i_wr_data     write data, i_wr_sel selects the bytes taken from it
//   i_clr_all     invalidate every line; overrides a same-cycle write
//   o_rd_valid    combinational valid bit at i_idx
//   o_rd_tag      combinational tag at i_idx
module dcache_wr_array
  import dcache_pkg::*;
#(
  parameter int unsigned TAG_W          = 26,
  parameter int unsigned IDX_W          = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTE_SEL_WIDTH = 4,
  parameter int unsigned NUM_LINES      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IDX_W-1:0]          i_idx,
  input  logic                      i_wr_en,
  input  logic [TAG_W-1:0]          i_wr_tag,
  input  logic [DATA_WIDTH-1:0]     i_wr_data,
  input  logic [BYTE_SEL_WIDTH-1:0] i_wr_sel,
  input  logic                      i_clr_all,
  output logic                      o_rd_valid,
  output logic [TAG_W-1:0]          o_rd_tag
);

  type_dcache_line_t            r_lines [NUM_LINES];
  logic [LINE_DATA_MAX_W-1:0]   w_merged;
  logic [LINE_TAG_MAX_W-1:0]    w_rd_tag_full;

  assign o_rd_valid    = r_lines[i_idx].valid;
  assign w_rd_tag_full = r_lines[i_idx].tag;
  assign o_rd_tag      = w_rd_tag_full[TAG_W-1:0];

  // Old line data with the enabled bytes replaced.
  always_comb begin
    w_merged = r_lines[i_idx].data;
    for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
      if (i_wr_sel[b]) begin
        w_merged[8*b +: 8] = i_wr_data[8*b +: 8];
      end
    end
  end

  // Only the valid bits are reset; tag and data hold whatever they had.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_lines[i].valid <= 1'b0;
      end
    end else if (i_clr_all) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_lines[i].valid <= 1'b0;
      end
    end else if (i_wr_en) begin
      r_lines[i_idx].tag  <= LINE_TAG_MAX_W'(i_wr_tag);
      r_lines[i_idx].data <= w_merged;
    end
  end

endmodule

// File: rtl/dcache_stb_responder.sv
// dcache_stb_responder: store-buffer drain endpoint of the data cache.
// Takes one store at a time, updates the write-through no-allocate array on a hit,
// forwards writes to memory and returns a one-cycle ack to the store buffer.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   stb2dcache_*           store request (addr, wdata, sel_byte, w_en, req)
//   dmem_sel_i             request targets cacheable data memory; req ignored when 0
//   dcache2stb_ack/err     completion pulse; err marks a memory timeout
//   dcache_flush_i         invalidate all lines at the next edge
//   dcache2mem_*           word-aligned memory write, req held until mem2dcache_ack
//   mem2dcache_ack         memory accepted the write
// Optional feature: define DCACHE_STB_RESP_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog
// on the memory ack; otherwise MEM_WR waits forever and dcache2stb_err is 0.
module dcache_stb_responder
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTE_SEL_WIDTH = 4,
  parameter int unsigned NUM_LINES      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     stb2dcache_addr,
  input  logic [DATA_WIDTH-1:0]     stb2dcache_wdata,
  input  logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte,
  input  logic                      stb2dcache_w_en,
  input  logic                      stb2dcache_req,
  input  logic                      dmem_sel_i,
  output logic                      dcache2stb_ack,
  output logic                      dcache2stb_err,
  input  logic                      dcache_flush_i,
  output logic [ADDR_WIDTH-1:0]     dcache2mem_addr,
  output logic [DATA_WIDTH-1:0]     dcache2mem_wdata,
  output logic [BYTE_SEL_WIDTH-1:0] dcache2mem_sel_byte,
  output logic                      dcache2mem_w_en,
  output logic                      dcache2mem_req,
  input  logic                      mem2dcache_ack
);

  localparam int unsigned IDX_W = calc_idx_w(NUM_LINES);
  localparam int unsigned TAG_W = calc_tag_w(ADDR_WIDTH, NUM_LINES);

  type_dcache_resp_state_e   r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [BYTE_SEL_WIDTH-1:0] r_sel;
  logic                      r_wen;

  logic                      w_capture;
  logic                      w_in_mem;
  logic                      w_hit;
  logic                      w_rd_valid;
  logic [TAG_W-1:0]          w_rd_tag;
  logic [TAG_W-1:0]          w_tag;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_tmo;

  assign w_capture = (r_state == StIdle) && stb2dcache_req && dmem_sel_i;
  assign w_in_mem  = (r_state == StMemWr);
  assign w_idx     = r_addr[2 +: IDX_W];
  assign w_tag     = r_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_hit     = w_rd_valid && (w_rd_tag == w_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_wen   <= 1'b0;
    end else if (w_capture) begin
      r_addr  <= stb2dcache_addr;
      r_wdata <= stb2dcache_wdata;
      r_sel   <= stb2dcache_sel_byte;
      r_wen   <= stb2dcache_w_en;
    end
  end

  dcache_wr_array #(
    .TAG_W          (TAG_W),
    .IDX_W          (IDX_W),
    .DATA_WIDTH     (DATA_WIDTH),
    .BYTE_SEL_WIDTH (BYTE_SEL_WIDTH),
    .NUM_LINES      (NUM_LINES)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_idx      (w_idx),
    .i_wr_en    ((r_state == StLookup) && w_hit && r_wen),
    .i_wr_tag   (w_tag),
    .i_wr_data  (r_wdata),
    .i_wr_sel   (r_sel),
    .i_clr_all  (dcache_flush_i),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag)
  );

`ifdef DCACHE_STB_RESP_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;

  // Counts MEM_WR cycles already spent; the last allowed cycle is TIMEOUT_CYCLES-1.
  assign w_tmo = w_in_mem && !mem2dcache_ack && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_cnt <= w_in_mem ? r_tmo_cnt + TMO_W'(1) : '0;
      if (w_tmo) begin
        r_tmo_err <= 1'b1;
      end else if (w_capture) begin
        r_tmo_err <= 1'b0;
      end
    end
  end

  assign dcache2stb_err = (r_state == StAck) && r_tmo_err;
`else
  assign w_tmo          = 1'b0;
  assign dcache2stb_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_capture) w_state_next = StLookup;
      StLookup: w_state_next = r_wen ? StMemWr : StAck;
      StMemWr:  if (mem2dcache_ack || w_tmo) w_state_next = StAck;
      StAck:    w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Memory outputs are gated by state so they read 0 outside MEM_WR and during reset.
  assign dcache2stb_ack      = (r_state == StAck);
  assign dcache2mem_req      = w_in_mem;
  assign dcache2mem_w_en     = w_in_mem && r_wen;
  assign dcache2mem_addr     = w_in_mem ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dcache2mem_wdata    = w_in_mem ? r_wdata : '0;
  assign dcache2mem_sel_byte = w_in_mem ? r_sel : '0;

endmodule

// File: doc/dcache_stb_responder.md
# dcache_stb_responder

Data-cache write port that sits at the dcache end of the store-buffer drain interface. It accepts one buffered store at a time from the store buffer and applies it as a byte-masked update to a small direct-mapped, write-through, no-write-allocate word array on a hit. It forwards every store to the memory bus and returns a single-cycle acknowledge to the store buffer once memory has accepted the write.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- BYTE_SEL_WIDTH, 4, byte-enable width (DATA_WIDTH/8)
- NUM_LINES, 16, array lines of one word each; power of two, ≥2
- TIMEOUT_CYCLES, 64, memory-ack watchdog limit; used only with the macro

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- stb2dcache_addr  in  ADDR_WIDTH  store address
- stb2dcache_wdata  in  DATA_WIDTH  store data
- stb2dcache_sel_byte  in  BYTE_SEL_WIDTH  byte enables
- stb2dcache_w_en  in  1  1 = write, 0 = no-op request
- stb2dcache_req  in  1  request valid; held with fields stable until ack
- dmem_sel_i  in  1  request targets cacheable data memory
- dcache2stb_ack  out  1  one-cycle completion pulse
- dcache2stb_err  out  1  pulses with ack on memory timeout
- dcache_flush_i  in  1  invalidate all lines
- dcache2mem_addr  out  ADDR_WIDTH  word-aligned memory write address
- dcache2mem_wdata  out  DATA_WIDTH  memory write data
- dcache2mem_sel_byte  out  BYTE_SEL_WIDTH  memory byte enables
- dcache2mem_w_en  out  1  memory write enable
- dcache2mem_req  out  1  memory request, held until ack
- mem2dcache_ack  in  1  memory accepted the write

## Operation
- Address split: offset = addr[1:0], ignored. IDX_W = log2(NUM_LINES). index = addr[2 +: IDX_W]. tag = addr[ADDR_WIDTH-1 : 2+IDX_W].
- FSM states: IDLE, LOOKUP, MEM_WR, ACK.
  - IDLE: when stb2dcache_req && dmem_sel_i, register addr/wdata/sel_byte/w_en and go to LOOKUP. The request is ignored (never acked) while dmem_sel_i = 0.
  - LOOKUP: hit = valid[index] && tag_arr[index] == tag.
    - Hit with w_en = 1: write each byte i where sel_byte[i] = 1 into data[index]. Other bytes are unchanged.
    - Miss: array untouched (no allocate).
    - Next state is MEM_WR if w_en = 1, otherwise ACK.
  - MEM_WR: drive dcache2mem_* from the registered fields, with addr[1:0] = 0 and dcache2mem_req = 1. Go to ACK on mem2dcache_ack.
  - ACK: dcache2stb_ack = 1 for exactly one cycle, then go to IDLE.
- Flush: dcache_flush_i clears all valid bits at the next edge in any state. If it coincides with a LOOKUP hit, the flush wins and the data/tag write is suppressed. The FSM is unaffected.
- sel_byte = 0 with w_en = 1: still goes through MEM_WR; the array is unchanged.

## Timing
- Reset values: every output is 0, FSM = IDLE, all valid bits = 0. Data and tag arrays are not reset.
- Minimum latency: req sampled in cycle 0 → LOOKUP in cycle 1 → MEM_WR in cycle 2 (mem ack the same cycle) → ack in cycle 3. Each memory wait cycle adds one cycle.
- No-op request (w_en = 0): ack in cycle 2.
- The next request is accepted no earlier than the cycle after ack. A req still high during the ack cycle is not captured.
- dcache2mem_* stays stable from MEM_WR entry until the ack edge.
- Reset asserted mid-operation: outputs go to 0 immediately. An in-flight store is dropped without ack; the store buffer is reset by the same rst_n.
- The array write and the valid clear occur at the clock edge ending LOOKUP.

## Configuration
- DCACHE_STB_RESP_TIMEOUT_EN defined:
  - A counter runs in MEM_WR and is cleared on entry.
  - If it reaches TIMEOUT_CYCLES without mem2dcache_ack, dcache2mem_req drops and the FSM goes to ACK.
  - In that ACK cycle, dcache2stb_err = 1 alongside dcache2stb_ack.
- Undefined: MEM_WR waits indefinitely, the counter is not built, and dcache2stb_err is tied to 0.

## Structure
- Package dcache_pkg holds:
  - the state enum type_dcache_resp_state_e
  - functions that derive IDX_W and TAG_W from parameters
  - the line struct {valid, tag, data}
- Sub-module dcache_wr_array contains the tag/valid/data storage: byte-masked write port, combinational read at index, bulk valid clear.
- The FSM and the memory interface live in the top module.

## Test plan
- Reset, then req addr 0x0000_0010, wdata 0xAABBCCDD, sel 0xF, mem acks immediately → mem write at 0x10 in cycle 2; ack in cycle 3; no array change (miss).
- Preload line 4 with 0x11223344 via backdoor, then store to 0x10 with sel 0x3, data 0xAABBCCDD → data[4] = 0x1122CCDD; mem sel_byte = 0x3.
- Hold mem2dcache_ack low for 5 cycles → req/addr stable throughout; ack in cycle 8; err = 0.
- Request with dmem_sel_i = 0 for 10 cycles → no ack, no mem request. Then raise dmem_sel_i → normal completion.
- Flush asserted in the same cycle as a LOOKUP hit → no data write; all valid bits = 0; mem write and ack still occur.
- With DCACHE_STB_RESP_TIMEOUT_EN and TIMEOUT_CYCLES = 8, mem never acks → req drops after 8 MEM_WR cycles; ack and err pulse together. Separately, rst_n low in MEM_WR → all outputs 0 asynchronously.
